// File: rtl/uart_xmit_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART byte transmitter among NUM_REQ requesters.
// Optional frame watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_xmit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_l,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      xmitH_o,
    output logic [DATA_W-1:0]         xmit_dataH_o,
    input  logic                      xmit_doneH_i,
    output logic                      timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_xmit_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_ACK
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic               winner_vld;
    logic [NUM_REQ-1:0] win_onehot;
    logic               frame_expired;

    // Search starts just after the last winner; wrap is an explicit compare so
    // non-power-of-2 NUM_REQ never indexes past the last requester.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        winner     = rr_ptr;
        winner_vld = 1'b0;
        win_onehot = '0;
        idx        = 0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PTR_W'(idx);
            if (!winner_vld && req_i[cand]) begin
                winner     = cand;
                winner_vld = 1'b1;
            end
        end
        win_onehot[winner] = 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] frame_cnt;

    assign frame_expired = (state == S_WAIT_LOW || state == S_WAIT_HIGH) &&
                           (frame_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            frame_cnt <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                frame_cnt <= '0;
            end else if (state == S_WAIT_LOW || state == S_WAIT_HIGH) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (frame_expired) begin
                timeout_o <= 1'b1;
            end
        end
    end
`else
    assign frame_expired = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state        <= S_IDLE;
            rr_ptr       <= PTR_W'(NUM_REQ - 1);
            ack_o        <= '0;
            grant_o      <= '0;
            busy_o       <= 1'b0;
            xmitH_o      <= 1'b0;
            xmit_dataH_o <= '0;
        end else begin
            xmitH_o <= 1'b0;
            ack_o   <= '0;
            case (state)
                S_IDLE: begin
                    if (|req_i && xmit_doneH_i) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (winner_vld) begin
                        grant_o      <= win_onehot;
                        xmit_dataH_o <= req_data_i[winner*DATA_W +: DATA_W];
                        rr_ptr       <= winner;
                        busy_o       <= 1'b1;
                        xmitH_o      <= 1'b1;
                        state        <= S_LAUNCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (frame_expired) begin
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                    end else if (!xmit_doneH_i) begin
                        state <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (frame_expired) begin
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                    end else if (xmit_doneH_i) begin
                        ack_o <= grant_o;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
